pair_sched: RTL and testbench
=============================

PAIR_SCHED -- requirements
Module: pair_sched

Interface
REQ-001 Parameter N_OBJ, default 8, SHALL set the number of objects held (legal range 2..16).
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum cycles spent waiting for one detector result.
REQ-003 Localparam NPAIR = N_OBJ*(N_OBJ-1)/2 SHALL set the pair count (28 at default).
REQ-004 Ports, one per line:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- load_en  in  1  write one object record this cycle.
- load_idx  in  4  object slot to write.
- load_x, load_y, load_vx, load_vy  in  16 each  object position and velocity.
- r2_in  in  16  squared-radius threshold, captured on start.
- start  in  1  begin a sweep of all pairs.
- x1, y1, vx1, vy1, x2, y2, vx2, vy2  out  16 each  pair operands to the detector.
- r2  out  16  captured threshold to the detector.
- in_rdy  out  1  operands valid; held high until det_done.
- det_done  in  1  one-cycle pulse: detector result valid.
- trial  in  1  detector collision flag, sampled with det_done.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- coll_map  out  NPAIR  bit p = collision result of pair p.
- coll_count  out  $clog2(NPAIR+1)  number of set bits in coll_map.
- timeout_err  out  1  sticky: at least one pair timed out during the last sweep.

Function
REQ-005 Object storage SHALL be N_OBJ records of 4x16 bits, written on any clock edge with load_en=1, busy=0 and load_idx<N_OBJ; all other writes SHALL be ignored.
REQ-006 Pairs SHALL be enumerated i=0..N_OBJ-2, j=i+1..N_OBJ-1, with pair index p incrementing from 0; object i drives the *1 ports and object j drives the *2 ports.
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT, NEXT, FIN.
REQ-008 In IDLE, start=1 SHALL capture r2_in, clear coll_map, coll_count and timeout_err, set i=0, j=1, p=0, and move to ISSUE; busy SHALL go high on the following edge.
REQ-009 In ISSUE, the operand ports SHALL be registered from slots i and j, in_rdy SHALL be set to 1, and the FSM SHALL move to WAIT.
REQ-010 In WAIT, det_done=1 SHALL write trial into coll_map[p], add trial to coll_count, drop in_rdy, and move to NEXT.
REQ-011 In WAIT, if TIMEOUT cycles elapse without det_done, the block SHALL write 0 to coll_map[p], set timeout_err, drop in_rdy, and move to NEXT.
REQ-012 In NEXT, if p=NPAIR-1 the FSM SHALL move to FIN; otherwise it SHALL advance j, or on j=N_OBJ-1 set i=i+1 and j=i+2, increment p, and return to ISSUE.
REQ-013 FIN SHALL assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-014 Operand ports SHALL hold stable while in_rdy=1.
REQ-015 start while busy=1, and det_done outside WAIT, SHALL be ignored.
REQ-016 When load_en and start occur in the same IDLE cycle, the written record SHALL be stored and SHALL be visible to the sweep.
REQ-017 coll_map, coll_count and timeout_err SHALL hold their values after FIN until the next accepted start.
REQ-018 Minimum per-pair latency SHALL be 3 cycles plus the detector latency: ISSUE, then WAIT ending on det_done, then NEXT.

Reset
REQ-019 On reset=1, asynchronously: the FSM SHALL go to IDLE; i, j, p and the timeout counter SHALL clear; all outputs SHALL be 0, including in_rdy, busy, done, coll_map, coll_count, timeout_err and all operand ports.
REQ-020 Object storage SHALL clear to 0 on reset.
REQ-021 Reset during a sweep SHALL abort it with no done pulse.

Structure
REQ-022 A shared package coll_pkg SHALL hold the FSM state enum, the 16-bit word typedef, the object-record typedef {x,y,vx,vy}, and the default N_OBJ and TIMEOUT values.
REQ-023 The design SHALL consist of one sub-module, obj_regfile: N_OBJ records with one write port and two read ports.

Verification
REQ-024 Load N_OBJ=3 objects, start, and respond with det_done at 10 cycles and trial=1,0,1 -> pairs issued (0,1),(0,2),(1,2); coll_map=3'b101; coll_count=2; one done pulse.
REQ-025 Default N_OBJ=8 with every trial=1 -> 28 in_rdy handshakes; coll_map all ones; coll_count=28; timeout_err=0.
REQ-026 Withhold det_done on pair 2 -> in_rdy drops after 64 WAIT cycles; coll_map[2]=0; timeout_err=1; sweep completes.
REQ-027 Assert start, and pulse load_en with load_idx=0, during busy -> no restart; slot 0 unchanged on the next sweep.
REQ-028 Assert reset during WAIT of pair 5 -> all outputs 0 immediately; no done pulse; a fresh start sweeps from pair 0.
REQ-029 Pulse det_done while IDLE, then load_idx=9 with N_OBJ=8 -> no state change; storage unchanged.

Source files
------------

// File: rtl/coll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coll_pkg
// Description : Shared types and defaults for the pair collision scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package coll_pkg;

    localparam int DEF_N_OBJ   = 8;
    localparam int DEF_TIMEOUT = 64;

    typedef logic [15:0] word_t;

    typedef struct packed {
        word_t x;
        word_t y;
        word_t vx;
        word_t vy;
    } obj_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_FIN   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/obj_regfile.sv
`default_nettype none
// ============================================================================
// Module      : obj_regfile
// Description : N_OBJ object records, one write port and two combinational
//               read ports; out-of-range addresses read and write nothing.
// Revision    : 1.0 - initial release
// ============================================================================
module obj_regfile
    import coll_pkg::*;
#(
    parameter int N_OBJ = DEF_N_OBJ
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       we,
    input  logic [3:0] waddr,
    input  obj_t       wdata,
    input  logic [3:0] raddr_a,
    input  logic [3:0] raddr_b,
    output obj_t       rdata_a,
    output obj_t       rdata_b
);

    obj_t mem [N_OBJ];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_OBJ; k++) begin
                mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_OBJ; k++) begin
                if (we && (waddr == 4'(k))) begin
                    mem[k] <= wdata;
                end
            end
        end
    end

    // Decoded read muxes keep the address width independent of N_OBJ.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int k = 0; k < N_OBJ; k++) begin
            if (raddr_a == 4'(k)) begin
                rdata_a = mem[k];
            end
            if (raddr_b == 4'(k)) begin
                rdata_b = mem[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pair_sched.sv
`default_nettype none
// ============================================================================
// Module      : pair_sched
// Description : Walks every object pair (i<j), hands operands to an external
//               collision detector and gathers the per-pair results.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_sched
    import coll_pkg::*;
#(
    parameter int N_OBJ   = DEF_N_OBJ,
    parameter int TIMEOUT = DEF_TIMEOUT,
    localparam int NPAIR  = N_OBJ * (N_OBJ - 1) / 2,
    localparam int CW     = $clog2(NPAIR + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_en,
    input  logic [3:0]       load_idx,
    input  logic [15:0]      load_x,
    input  logic [15:0]      load_y,
    input  logic [15:0]      load_vx,
    input  logic [15:0]      load_vy,
    input  logic [15:0]      r2_in,
    input  logic             start,
    output logic [15:0]      x1,
    output logic [15:0]      y1,
    output logic [15:0]      vx1,
    output logic [15:0]      vy1,
    output logic [15:0]      x2,
    output logic [15:0]      y2,
    output logic [15:0]      vx2,
    output logic [15:0]      vy2,
    output logic [15:0]      r2,
    output logic             in_rdy,
    input  logic             det_done,
    input  logic             trial,
    output logic             busy,
    output logic             done,
    output logic [NPAIR-1:0] coll_map,
    output logic [CW-1:0]    coll_count,
    output logic             timeout_err
);

    localparam int PW = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t         state;
    state_t         state_nx;
    logic           take_start;
    logic           do_issue;
    logic           resp;
    logic           tmo;
    logic           adv;
    logic           fin;

    logic [3:0]     i;
    logic [3:0]     j;
    logic [PW-1:0]  p;
    logic [TW-1:0]  tcnt;
    logic [NPAIR-1:0] mask;
    logic           last_pair;
    logic           last_j;
    logic           wr_en;

    obj_t           wr_rec;
    obj_t           rd_a;
    obj_t           rd_b;
    obj_t           op_a;
    obj_t           op_b;

    assign wr_en        = load_en && !busy;
    assign wr_rec.x     = load_x;
    assign wr_rec.y     = load_y;
    assign wr_rec.vx    = load_vx;
    assign wr_rec.vy    = load_vy;

    obj_regfile #(
        .N_OBJ   (N_OBJ)
    ) u_regfile (
        .clock   (clock),
        .reset   (reset),
        .we      (wr_en),
        .waddr   (load_idx),
        .wdata   (wr_rec),
        .raddr_a (i),
        .raddr_b (j),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    assign mask      = NPAIR'(1) << p;
    assign last_pair = (p == PW'(NPAIR - 1));
    assign last_j    = (j == 4'(N_OBJ - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        take_start = 1'b0;
        do_issue   = 1'b0;
        resp       = 1'b0;
        tmo        = 1'b0;
        adv        = 1'b0;
        fin        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    take_start = 1'b1;
                    state_nx   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                do_issue = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (det_done) begin
                    resp     = 1'b1;
                    state_nx = S_NEXT;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    tmo      = 1'b1;
                    state_nx = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_pair) begin
                    fin      = 1'b1;
                    state_nx = S_FIN;
                end else begin
                    adv      = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i           <= '0;
            j           <= '0;
            p           <= '0;
            tcnt        <= '0;
            op_a        <= '0;
            op_b        <= '0;
            r2          <= '0;
            in_rdy      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            coll_map    <= '0;
            coll_count  <= '0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take_start) begin
                r2          <= r2_in;
                coll_map    <= '0;
                coll_count  <= '0;
                timeout_err <= 1'b0;
                i           <= 4'd0;
                j           <= 4'd1;
                p           <= '0;
                busy        <= 1'b1;
            end
            if (do_issue) begin
                op_a   <= rd_a;
                op_b   <= rd_b;
                in_rdy <= 1'b1;
                tcnt   <= '0;
            end
            if ((state == S_WAIT) && !resp && !tmo) begin
                tcnt <= tcnt + TW'(1);
            end
            if (resp) begin
                coll_map   <= (coll_map & ~mask) | (trial ? mask : '0);
                coll_count <= coll_count + CW'(trial);
                in_rdy     <= 1'b0;
            end
            // A timed-out pair is recorded as no collision.
            if (tmo) begin
                coll_map    <= coll_map & ~mask;
                timeout_err <= 1'b1;
                in_rdy      <= 1'b0;
            end
            if (adv) begin
                p <= p + PW'(1);
                if (last_j) begin
                    i <= i + 4'd1;
                    j <= i + 4'd2;
                end else begin
                    j <= j + 4'd1;
                end
            end
            if (fin) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    assign x1  = op_a.x;
    assign y1  = op_a.y;
    assign vx1 = op_a.vx;
    assign vy1 = op_a.vy;
    assign x2  = op_b.x;
    assign y2  = op_b.y;
    assign vx2 = op_b.vx;
    assign vy2 = op_b.vy;

endmodule
`default_nettype wire

// File: tb/tb_pair_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pair_sched
// Description : Directed self-checking bench for pair_sched (N_OBJ=8 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_sched;
    import coll_pkg::*;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        load_en;
    logic [3:0]  load_idx;
    logic [15:0] load_x, load_y, load_vx, load_vy, r2_in;
    logic        start, det_done, trial, sel;

    wire start8 = start & ~sel;
    wire start3 = start & sel;
    wire det8   = det_done & ~sel;
    wire det3   = det_done & sel;

    logic [15:0] x1_8, y1_8, vx1_8, vy1_8, x2_8, y2_8, vx2_8, vy2_8, r2_8;
    logic        in_rdy8, busy8, done8, terr8;
    logic [27:0] map8;
    logic [4:0]  cnt8;

    logic [15:0] x1_3, y1_3, vx1_3, vy1_3, x2_3, y2_3, vx2_3, vy2_3, r2_3;
    logic        in_rdy3, busy3, done3, terr3;
    logic [2:0]  map3;
    logic [1:0]  cnt3;

    pair_sched dut8 (
        .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
        .r2_in(r2_in), .start(start8),
        .x1(x1_8), .y1(y1_8), .vx1(vx1_8), .vy1(vy1_8),
        .x2(x2_8), .y2(y2_8), .vx2(vx2_8), .vy2(vy2_8),
        .r2(r2_8), .in_rdy(in_rdy8), .det_done(det8), .trial(trial),
        .busy(busy8), .done(done8), .coll_map(map8), .coll_count(cnt8),
        .timeout_err(terr8)
    );

    pair_sched #(.N_OBJ(3), .TIMEOUT(64)) dut3 (
        .clock(clock), .reset(reset), .load_en(load_en), .load_idx(load_idx),
        .load_x(load_x), .load_y(load_y), .load_vx(load_vx), .load_vy(load_vy),
        .r2_in(r2_in), .start(start3),
        .x1(x1_3), .y1(y1_3), .vx1(vx1_3), .vy1(vy1_3),
        .x2(x2_3), .y2(y2_3), .vx2(vx2_3), .vy2(vy2_3),
        .r2(r2_3), .in_rdy(in_rdy3), .det_done(det3), .trial(trial),
        .busy(busy3), .done(done3), .coll_map(map3), .coll_count(cnt3),
        .timeout_err(terr3)
    );

    // Views of whichever instance the current step addresses.
    logic [63:0] cur_op1, cur_op2;
    logic [15:0] cur_r2;
    logic        cur_in_rdy, cur_busy, cur_done;
    assign cur_op1    = sel ? {x1_3, y1_3, vx1_3, vy1_3} : {x1_8, y1_8, vx1_8, vy1_8};
    assign cur_op2    = sel ? {x2_3, y2_3, vx2_3, vy2_3} : {x2_8, y2_8, vx2_8, vy2_8};
    assign cur_r2     = sel ? r2_3 : r2_8;
    assign cur_in_rdy = sel ? in_rdy3 : in_rdy8;
    assign cur_busy   = sel ? busy3 : busy8;
    assign cur_done   = sel ? done3 : done8;

    int checks = 0;
    int errors = 0;
    int hs = 0;
    int done_cnt8 = 0;
    int done_cnt3 = 0;
    int p, n, exp_cnt;
    logic        t;
    logic [27:0] exp_map;
    obj_t        zero_obj;

    always @(negedge clock) begin
        if (done8 === 1'b1) done_cnt8++;
        if (done3 === 1'b1) done_cnt3++;
    end

    function automatic obj_t mk(input int k);
        obj_t o;
        o.x  = 16'h1000 + 16'(k);
        o.y  = 16'h2000 + 16'(k);
        o.vx = 16'h3000 + 16'(k);
        o.vy = 16'h4000 + 16'(k);
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic drive_load(input logic [3:0] idx, input obj_t o);
        load_en  = 1'b1;
        load_idx = idx;
        load_x   = o.x;
        load_y   = o.y;
        load_vx  = o.vx;
        load_vy  = o.vy;
    endtask

    task automatic load(input logic [3:0] idx, input obj_t o);
        drive_load(idx, o);
        tick();
        load_en = 1'b0;
    endtask

    task automatic do_start(input logic [15:0] r2v);
        start = 1'b1;
        r2_in = r2v;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        chk("busy_after_start", cur_busy, 1'b1);
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (cur_in_rdy !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        chk("in_rdy_rise", cur_in_rdy, 1'b1);
    endtask

    task automatic serve(input obj_t ea, input obj_t eb, input int delay,
                         input logic tv, input logic [15:0] er2);
        wait_rdy();
        chk("op1", cur_op1, ea);
        chk("op2", cur_op2, eb);
        chk("r2", cur_r2, er2);
        repeat (delay) tick();
        chk("op_hold", {cur_op1[63:48], cur_op2[63:48]}, {ea.x, eb.x});
        det_done = 1'b1;
        trial    = tv;
        tick();
        det_done = 1'b0;
        trial    = 1'b0;
        chk("in_rdy_drop", cur_in_rdy, 1'b0);
        hs++;
    endtask

    task automatic wait_done();
        int k = 0;
        while (cur_done !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        chk("done_pulse", cur_done, 1'b1);
        chk("busy_at_done", cur_busy, 1'b0);
        tick();
        chk("done_single", cur_done, 1'b0);
    endtask

    initial begin
        zero_obj = '0;
        reset = 1'b1; load_en = 1'b0; load_idx = '0;
        load_x = '0; load_y = '0; load_vx = '0; load_vy = '0;
        r2_in = '0; start = 1'b0; det_done = 1'b0; trial = 1'b0; sel = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", busy8, 1'b0);
        chk("rst_in_rdy", in_rdy8, 1'b0);
        chk("rst_done", done8, 1'b0);
        chk("rst_map", map8, 28'h0);
        chk("rst_cnt", cnt8, 5'd0);
        chk("rst_terr", terr8, 1'b0);
        chk("rst_ops", {x1_8, y1_8, x2_8, vy2_8}, 64'h0);
        chk("rst_r2", r2_8, 16'h0);
        chk("rst_busy3", busy3, 1'b0);

        // Stray det_done while idle
        det_done = 1'b1; trial = 1'b1;
        tick();
        det_done = 1'b0; trial = 1'b0;
        tick();
        chk("idle_det_busy", busy8, 1'b0);
        chk("idle_det_rdy", in_rdy8, 1'b0);
        chk("idle_det_map", {map8, cnt8}, 33'h0);

        for (int k = 0; k < 8; k++) load(4'(k), mk(k));
        load(4'd9, mk(9'h1ff));

        // Three-object sweep, detector latency 10
        sel = 1'b1;
        do_start(16'h0123);
        serve(mk(0), mk(1), 10, 1'b1, 16'h0123);
        serve(mk(0), mk(2), 10, 1'b0, 16'h0123);
        serve(mk(1), mk(2), 10, 1'b1, 16'h0123);
        wait_done();
        chk("n3_map", map3, 3'b101);
        chk("n3_cnt", cnt3, 2'd2);
        chk("n3_terr", terr3, 1'b0);
        chk("n3_done_cnt", done_cnt3, 1);

        // Full sweep, slot 0 rewritten in the start cycle
        sel = 1'b0;
        load(4'd0, mk(16'haaa));
        drive_load(4'd0, mk(0));
        do_start(16'h0123);
        hs = 0;
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 8; j++)
                serve(mk(i), mk(j), 1, 1'b1, 16'h0123);
        wait_done();
        chk("full_hs", hs, 28);
        chk("full_map", map8, 28'hfffffff);
        chk("full_cnt", cnt8, 5'd28);
        chk("full_terr", terr8, 1'b0);
        chk("full_done_cnt", done_cnt8, 1);
        repeat (5) tick();
        chk("hold_map", {map8, cnt8}, {28'hfffffff, 5'd28});

        // Timeout on pair 2, start and load attempted while busy
        do_start(16'h0456);
        p = 0; exp_cnt = 0; exp_map = '0;
        for (int i = 0; i < 7; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                if (p == 2) begin
                    wait_rdy();
                    n = 0;
                    while (cur_in_rdy === 1'b1 && n < 200) begin
                        n++;
                        if (n == 1) begin
                            start = 1'b1;
                            r2_in = 16'hbeef;
                            drive_load(4'd0, mk(16'h0fff));
                        end
                        tick();
                        if (n == 1) begin
                            start = 1'b0;
                            load_en = 1'b0;
                        end
                    end
                    chk("timeout_len", n, 64);
                end else begin
                    t = (p < 2) ? 1'b1 : p[0];
                    exp_map[p] = t;
                    exp_cnt += int'(t);
                    serve(mk(i), mk(j), 2, t, 16'h0456);
                end
                p++;
            end
        end
        wait_done();
        chk("tmo_map", map8, exp_map);
        chk("tmo_cnt", cnt8, 5'(exp_cnt));
        chk("tmo_exp_cnt", exp_cnt, 15);
        chk("tmo_terr", terr8, 1'b1);
        chk("tmo_done_cnt", done_cnt8, 2);

        // Reset during WAIT of pair 5
        do_start(16'h0789);
        p = 0;
        for (int j = 1; j < 6; j++) serve(mk(0), mk(j), 0, 1'b1, 16'h0789);
        wait_rdy();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_rdy_busy", {in_rdy8, busy8, done8, terr8}, 4'h0);
        chk("arst_ops", {x1_8, vy1_8, x2_8, vy2_8}, 64'h0);
        chk("arst_map", {map8, cnt8, r2_8}, 49'h0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("arst_no_done", done_cnt8, 2);

        // Fresh sweep after reset: storage cleared except reloaded slot 2
        load(4'd2, mk(2));
        do_start(16'h0011);
        hs = 0;
        for (int i = 0; i < 7; i++)
            for (int j = i + 1; j < 8; j++)
                serve((i == 2) ? mk(2) : zero_obj, (j == 2) ? mk(2) : zero_obj,
                      0, 1'b0, 16'h0011);
        wait_done();
        chk("post_hs", hs, 28);
        chk("post_map", {map8, cnt8}, 33'h0);
        chk("post_done_cnt", done_cnt8, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
